mem_access_initiator: RTL and testbench
=======================================

Name: mem_access_initiator

Overview:
- Core-side initiator for the shared-DRAM memory control unit protocol. Latches one batched read or write request for 1-4 cores, then drives the per-core address and data registers and the 2-bit read/write command lines for the memory control unit.
- For reads, collects the per-core data bytes the unit returns and presents them with a one-cycle done pulse. Sits between the matrix-multiplier core array and the memory control unit.

Parameters:
- ADDR_W, 16, per-core address width.
- DATA_W, 8, per-core data width.
- MAX_CORES, 4, number of core slots; fixed at 4, as the port list is flat.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  request strobe; sampled only in IDLE.
- i_we  in  1  1 = write batch, 0 = read batch.
- i_noc  in  3  number of active cores for the batch.
- i_addr1..i_addr4  in  ADDR_W  per-core request address.
- i_wdata1..i_wdata4  in  DATA_W  per-core write data.
- o_busy  out  1  batch in progress.
- o_done  out  1  one-cycle completion pulse.
- o_rdata1..o_rdata4  out  DATA_W  per-core read result, held until the next read batch.
- o_read  out  2  command to the memory control unit: bit0 = DRAM read enable, bit1 = first-slot marker.
- o_write  out  2  command to the memory control unit: bit0 = DRAM write enable, bit1 = first-slot marker.
- o_noc  out  3  latched core count driven to the memory control unit.
- o_ar1..o_ar4  out  ADDR_W  registered addresses to the memory control unit.
- o_dw1..o_dw4  out  DATA_W  registered write data to the memory control unit.
- i_dr1..i_dr4  in  DATA_W  read data from the memory control unit. Its output registers load on the falling clock edge.

Behaviour:
- Reset (async, i_rst_n=0) puts the block in IDLE and clears the following to 0: o_busy, o_done, o_read, o_write, o_noc, o_ar*, o_dw*, o_rdata*, the slot counter and the latched request. Reset mid-batch aborts the batch immediately with no done pulse.
- FSM states: IDLE, ISSUE, CAPTURE, DONE.
- IDLE to ISSUE: on i_start=1 with i_noc!=0, latch i_we, i_addr*, i_wdata* and n.
  - n = i_noc, clamped to 4 when i_noc>4.
  - o_ar*/o_dw* take the latched values at this edge and stay stable until the next accepted start.
  - Inactive slots (index > n) latch 0.
  - o_noc=n.
  - o_busy goes to 1 at this edge.
- i_start with i_noc=0 is ignored; the block stays in IDLE with no done pulse.
- ISSUE lasts exactly n cycles; the slot counter runs 0..n-1 and the memory control unit services slot k in cycle k.
  - Read batch: o_read={slot==0,1}, o_write=2'b00.
  - Write batch: o_write={slot==0,1}, o_read=2'b00.
  - After slot n-1, go to CAPTURE.
- CAPTURE (1 cycle): o_read=o_write=2'b00.
  - Read batch: o_rdata1..o_rdatan load i_dr1..i_drn at the end of this cycle. Inactive o_rdata hold their previous values.
  - Write batch: o_rdata* all hold.
- DONE (1 cycle): o_done=1, o_busy=0, then return to IDLE.
  - A new batch can be accepted on the first IDLE cycle after DONE.
- Latency: accept edge to o_done high = n+2 cycles; o_busy is high for n+1 cycles.
- i_start while not in IDLE is ignored and not queued.
- o_read[0] and o_write[0] are never both 1.
- o_busy and o_done are never both 1.

Optional Feature:
- Macro: MEM_ACCESS_COUNT_EN.
- When defined:
  - Adds output o_access_count [15:0].
  - Increments by 1 on every DONE cycle, saturating at 16'hFFFF.
  - Reset to 0 by i_rst_n.
  - Adds input i_count_clr (1 bit), a synchronous clear.
  - If i_count_clr and DONE coincide, the clear wins and the count ends at 0.
- When undefined: neither port exists and the behaviour is otherwise identical.

Test Plan:
- Reset, then read batch with i_noc=4, addrs 16'h0010/0011/0012/0013; bench model returns 8'hA1..A4 -> o_read = 11, 01, 01, 01 over 4 cycles, then 00; o_done 6 cycles after accept; o_rdata1..4 = A1..A4.
- Write batch with i_noc=2, wdata 8'h5A/8'hC3 to 16'h0100/0101 -> o_write = 11, 01, then 00; o_dw1/2 = 5A/C3 held stable through ISSUE; o_read stays 00; o_rdata unchanged; done 4 cycles after accept.
- i_noc=0 with i_start -> no busy, no done, all command lines 00. i_noc=7 -> treated as 4: o_noc=4 and 4 ISSUE cycles.
- i_start re-pulsed during ISSUE of an i_noc=3 read -> ignored; exactly one o_done; start accepted again the cycle after DONE.
- i_rst_n pulsed low mid-ISSUE (slot 1 of 4) -> all outputs 0 asynchronously; no o_done; a fresh i_noc=1 read then completes in 3 cycles.
- With MEM_ACCESS_COUNT_EN: 3 batches -> o_access_count=3. i_count_clr coincident with the 4th DONE -> count=0.

Source files
------------

// File: rtl/mem_access_initiator.sv
// Core-side initiator for the shared-DRAM memory control unit: latches a 1-4 core batch, sequences the
// per-slot read/write commands, captures read data and pulses done. Optional counter: MEM_ACCESS_COUNT_EN.
module mem_access_initiator #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int MAX_CORES = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_we,
    input  logic [2:0]        i_noc,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [ADDR_W-1:0] i_addr2,
    input  logic [ADDR_W-1:0] i_addr3,
    input  logic [ADDR_W-1:0] i_addr4,
    input  logic [DATA_W-1:0] i_wdata1,
    input  logic [DATA_W-1:0] i_wdata2,
    input  logic [DATA_W-1:0] i_wdata3,
    input  logic [DATA_W-1:0] i_wdata4,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2,
    output logic [DATA_W-1:0] o_rdata3,
    output logic [DATA_W-1:0] o_rdata4,
    output logic [1:0]        o_read,
    output logic [1:0]        o_write,
    output logic [2:0]        o_noc,
    output logic [ADDR_W-1:0] o_ar1,
    output logic [ADDR_W-1:0] o_ar2,
    output logic [ADDR_W-1:0] o_ar3,
    output logic [ADDR_W-1:0] o_ar4,
    output logic [DATA_W-1:0] o_dw1,
    output logic [DATA_W-1:0] o_dw2,
    output logic [DATA_W-1:0] o_dw3,
    output logic [DATA_W-1:0] o_dw4,
    input  logic [DATA_W-1:0] i_dr1,
    input  logic [DATA_W-1:0] i_dr2,
    input  logic [DATA_W-1:0] i_dr3,
    input  logic [DATA_W-1:0] i_dr4
`ifdef MEM_ACCESS_COUNT_EN
    ,
    input  logic              i_count_clr,
    output logic [15:0]       o_access_count
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_DONE} state_t;

    state_t                               state_q, state_d;
    logic [1:0]                           slot_q, slot_d;
    logic [2:0]                           n_q, n_d;
    logic                                 we_q, we_d;
    logic [MAX_CORES-1:0][ADDR_W-1:0]     ar_q, ar_d;
    logic [MAX_CORES-1:0][DATA_W-1:0]     dw_q, dw_d;
    logic [MAX_CORES-1:0][DATA_W-1:0]     rdata_q, rdata_d;

    logic [MAX_CORES-1:0][ADDR_W-1:0]     addr_in;
    logic [MAX_CORES-1:0][DATA_W-1:0]     wdata_in;
    logic [MAX_CORES-1:0][DATA_W-1:0]     dr_in;
    logic [2:0]                           n_clamp;
    logic [1:0]                           cmd;
    logic                                 busy, done;
    logic [1:0]                           rd_cmd, wr_cmd;

    // Index 0 is core 1 throughout.
    assign addr_in  = {i_addr4, i_addr3, i_addr2, i_addr1};
    assign wdata_in = {i_wdata4, i_wdata3, i_wdata2, i_wdata1};
    assign dr_in    = {i_dr4, i_dr3, i_dr2, i_dr1};
    assign n_clamp  = (i_noc > 3'd4) ? 3'd4 : i_noc;
    assign cmd      = {slot_q == 2'd0, 1'b1};

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        n_d     = n_q;
        we_d    = we_q;
        ar_d    = ar_q;
        dw_d    = dw_q;
        rdata_d = rdata_q;
        busy    = 1'b0;
        done    = 1'b0;
        rd_cmd  = 2'b00;
        wr_cmd  = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (i_start && (i_noc != 3'd0)) begin
                    state_d = S_ISSUE;
                    slot_d  = 2'd0;
                    we_d    = i_we;
                    n_d     = n_clamp;
                    for (int i = 0; i < MAX_CORES; i++) begin
                        ar_d[i] = (3'(i) < n_clamp) ? addr_in[i]  : '0;
                        dw_d[i] = (3'(i) < n_clamp) ? wdata_in[i] : '0;
                    end
                end
            end
            S_ISSUE: begin
                busy = 1'b1;
                if (we_q) wr_cmd = cmd;
                else      rd_cmd = cmd;
                if ({1'b0, slot_q} == n_q - 3'd1) state_d = S_CAPTURE;
                else                              slot_d  = slot_q + 2'd1;
            end
            S_CAPTURE: begin
                busy = 1'b1;
                // Unit read data has settled by now; only active slots are overwritten.
                if (!we_q) begin
                    for (int i = 0; i < MAX_CORES; i++)
                        if (3'(i) < n_q) rdata_d[i] = dr_in[i];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            slot_q  <= '0;
            n_q     <= '0;
            we_q    <= 1'b0;
            ar_q    <= '0;
            dw_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            n_q     <= n_d;
            we_q    <= we_d;
            ar_q    <= ar_d;
            dw_q    <= dw_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MEM_ACCESS_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_count_clr)                                cnt_d = 16'd0;
        else if (state_q == S_DONE && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) cnt_q <= 16'd0;
        else          cnt_q <= cnt_d;
    end

    assign o_access_count = cnt_q;
`endif

    assign o_busy   = busy;
    assign o_done   = done;
    assign o_read   = rd_cmd;
    assign o_write  = wr_cmd;
    assign o_noc    = n_q;
    assign o_ar1    = ar_q[0];
    assign o_ar2    = ar_q[1];
    assign o_ar3    = ar_q[2];
    assign o_ar4    = ar_q[3];
    assign o_dw1    = dw_q[0];
    assign o_dw2    = dw_q[1];
    assign o_dw3    = dw_q[2];
    assign o_dw4    = dw_q[3];
    assign o_rdata1 = rdata_q[0];
    assign o_rdata2 = rdata_q[1];
    assign o_rdata3 = rdata_q[2];
    assign o_rdata4 = rdata_q[3];

endmodule

// File: tb/tb_mem_access_initiator.sv
// Bench for mem_access_initiator: DRAM device emulation, batch-level reference model, directed + random stimulus.
module tb_mem_access_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  noc = 3'd0;
    logic [15:0] addr [4];
    logic [7:0]  wdata [4];
    logic [7:0]  rdata [4];
    logic [15:0] ar [4];
    logic [7:0]  dw [4];
    logic [7:0]  dr [4];
    logic        busy, done;
    logic [1:0]  rd, wr;
    logic [2:0]  onoc;
`ifdef MEM_ACCESS_COUNT_EN
    logic        count_clr = 1'b0;
    logic [15:0] acc_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_initiator dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_we(we), .i_noc(noc),
        .i_addr1(addr[0]), .i_addr2(addr[1]), .i_addr3(addr[2]), .i_addr4(addr[3]),
        .i_wdata1(wdata[0]), .i_wdata2(wdata[1]), .i_wdata3(wdata[2]), .i_wdata4(wdata[3]),
        .o_busy(busy), .o_done(done),
        .o_rdata1(rdata[0]), .o_rdata2(rdata[1]), .o_rdata3(rdata[2]), .o_rdata4(rdata[3]),
        .o_read(rd), .o_write(wr), .o_noc(onoc),
        .o_ar1(ar[0]), .o_ar2(ar[1]), .o_ar3(ar[2]), .o_ar4(ar[3]),
        .o_dw1(dw[0]), .o_dw2(dw[1]), .o_dw3(dw[2]), .o_dw4(dw[3]),
        .i_dr1(dr[0]), .i_dr2(dr[1]), .i_dr3(dr[2]), .i_dr4(dr[3])
`ifdef MEM_ACCESS_COUNT_EN
        , .i_count_clr(count_clr), .o_access_count(acc_cnt)
`endif
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures < 40) $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // DRAM device: services slot k in the k-th command cycle, output registers update on the falling edge.
    logic [7:0] dram [256];
    logic [1:0] dev_slot = 2'd0;
    logic [1:0] dev_s;
    assign dev_s = (rd[1] | wr[1]) ? 2'd0 : dev_slot + 2'd1;

    always @(negedge clk) begin
        if (rd[0] | wr[0]) dev_slot <= dev_s;
        if (rd[0]) dr[dev_s] <= dram[ar[dev_s][7:0]];
        if (wr[0]) dram[ar[dev_s][7:0]] <= dw[dev_s];
    end

    // Reference model: k = cycles since the accept edge (0 = idle); batch of n takes n ISSUE, 1 CAPTURE, 1 DONE.
    logic [7:0]  ref_mem [256];
    int          k, n;
    logic        mwe;
    logic [15:0] e_ar [4];
    logic [7:0]  e_dw [4];
    logic [7:0]  e_rd [4];
    logic [2:0]  e_noc;
    logic [15:0] e_cnt;
    int          acc_n;
    assign acc_n = (noc > 3'd4) ? 4 : int'(noc);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k <= 0; n <= 0; mwe <= 1'b0; e_noc <= 3'd0; e_cnt <= 16'd0;
            for (int i = 0; i < 4; i++) begin e_ar[i] <= 16'd0; e_dw[i] <= 8'd0; e_rd[i] <= 8'd0; end
        end else begin
            if (k == 0) begin
                if (start && noc != 3'd0) begin
                    n <= acc_n; mwe <= we; e_noc <= 3'(acc_n); k <= 1;
                    for (int i = 0; i < 4; i++) begin
                        e_ar[i] <= (i < acc_n) ? addr[i] : 16'd0;
                        e_dw[i] <= (i < acc_n) ? wdata[i] : 8'd0;
                        if (we && i < acc_n) ref_mem[addr[i][7:0]] <= wdata[i];
                    end
                end
            end else if (k == n + 1) begin
                if (!mwe)
                    for (int i = 0; i < 4; i++) if (i < n) e_rd[i] <= ref_mem[e_ar[i][7:0]];
                k <= k + 1;
            end else if (k == n + 2) begin
                k <= 0;
            end else begin
                k <= k + 1;
            end
`ifdef MEM_ACCESS_COUNT_EN
            if (count_clr)                                   e_cnt <= 16'd0;
            else if (k > 0 && k == n + 2 && e_cnt != 16'hFFFF) e_cnt <= e_cnt + 16'd1;
`endif
        end
    end

    logic chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            logic [1:0] cmd;
            cmd = (k >= 1 && k <= n) ? {k == 1, 1'b1} : 2'b00;
            check("busy", 32'(busy), 32'(k >= 1 && k <= n + 1));
            check("done", 32'(done), 32'(k > 0 && k == n + 2));
            check("o_read", 32'(rd), 32'(mwe ? 2'b00 : cmd));
            check("o_write", 32'(wr), 32'(mwe ? cmd : 2'b00));
            check("o_noc", 32'(onoc), 32'(e_noc));
            for (int i = 0; i < 4; i++) begin
                check("o_ar", 32'(ar[i]), 32'(e_ar[i]));
                check("o_dw", 32'(dw[i]), 32'(e_dw[i]));
                check("o_rdata", 32'(rdata[i]), 32'(e_rd[i]));
            end
`ifdef MEM_ACCESS_COUNT_EN
            check("count", 32'(acc_cnt), 32'(e_cnt));
`endif
        end
    end

    logic [1:0] rd_seq [40];
    logic [1:0] wr_seq [40];
    logic [2:0] noc_seq [40];

    // Call just after a rising edge; returns just after the rising edge following the done pulse.
    task automatic run_batch(input logic w, input logic [2:0] nc, input int clr_at, output int lat);
        start = 1'b1; we = w; noc = nc; lat = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            rd_seq[c] = rd; wr_seq[c] = wr; noc_seq[c] = onoc;
            if (done) begin lat = c; break; end
            @(posedge clk); #1;
            start = 1'b0;
`ifdef MEM_ACCESS_COUNT_EN
            count_clr = (c + 1 == clr_at);
`endif
        end
        if (lat < 0) check("done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
`ifdef MEM_ACCESS_COUNT_EN
        count_clr = 1'b0;
`endif
    endtask

    task automatic set_req(input logic [15:0] a0, a1, a2, a3, input logic [7:0] d0, d1, d2, d3);
        addr[0] = a0; addr[1] = a1; addr[2] = a2; addr[3] = a3;
        wdata[0] = d0; wdata[1] = d1; wdata[2] = d2; wdata[3] = d3;
    endtask

    initial begin
        int lat, ndone;
        for (int i = 0; i < 256; i++) begin
            dram[i] = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        dram[16] = 8'hA1; dram[17] = 8'hA2; dram[18] = 8'hA3; dram[19] = 8'hA4;
        ref_mem[16] = 8'hA1; ref_mem[17] = 8'hA2; ref_mem[18] = 8'hA3; ref_mem[19] = 8'hA4;
        for (int i = 0; i < 4; i++) begin addr[i] = 16'd0; wdata[i] = 8'd0; dr[i] = 8'd0; end

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_noc", 32'(onoc), 32'd0);
        check("reset_rdata1", 32'(rdata[0]), 32'd0);
        @(posedge clk); #1;

        // Read batch of 4.
        set_req(16'h0010, 16'h0011, 16'h0012, 16'h0013, 8'h00, 8'h00, 8'h00, 8'h00);
        run_batch(1'b0, 3'd4, -1, lat);
        check("rd4_latency", 32'(lat), 32'd6);
        check("rd4_seq1", 32'(rd_seq[1]), 32'd3);
        check("rd4_seq2", 32'(rd_seq[2]), 32'd1);
        check("rd4_seq4", 32'(rd_seq[4]), 32'd1);
        check("rd4_seq5", 32'(rd_seq[5]), 32'd0);
        check("rd4_rdata1", 32'(rdata[0]), 32'hA1);
        check("rd4_rdata4", 32'(rdata[3]), 32'hA4);

        // Write batch of 2.
        set_req(16'h0100, 16'h0101, 16'h0222, 16'h0333, 8'h5A, 8'hC3, 8'h11, 8'h22);
        run_batch(1'b1, 3'd2, -1, lat);
        check("wr2_latency", 32'(lat), 32'd4);
        check("wr2_seq1", 32'(wr_seq[1]), 32'd3);
        check("wr2_seq2", 32'(wr_seq[2]), 32'd1);
        check("wr2_seq3", 32'(wr_seq[3]), 32'd0);
        check("wr2_read_idle", 32'(rd_seq[1] | rd_seq[2]), 32'd0);
        check("wr2_dw1", 32'(dw[0]), 32'h5A);
        check("wr2_dw2", 32'(dw[1]), 32'hC3);
        check("wr2_dw3_inactive", 32'(dw[2]), 32'h00);
        check("wr2_rdata_hold", 32'(rdata[0]), 32'hA1);

        // Zero-core start is ignored.
        start = 1'b1; noc = 3'd0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("noc0_busy", 32'(busy), 32'd0);
            check("noc0_done", 32'(done), 32'd0);
            @(posedge clk); #1;
            start = 1'b0;
        end

        // Core count above 4 clamps.
        set_req(16'h0010, 16'h0011, 16'h0012, 16'h0013, 8'h00, 8'h00, 8'h00, 8'h00);
        run_batch(1'b0, 3'd7, -1, lat);
        check("noc7_latency", 32'(lat), 32'd6);
        check("noc7_onoc", 32'(noc_seq[1]), 32'd4);

        // Start re-pulsed during ISSUE is ignored; restart on first idle cycle after DONE.
        set_req(16'h0001, 16'h0002, 16'h0003, 16'h0004, 8'h00, 8'h00, 8'h00, 8'h00);
        start = 1'b1; we = 1'b0; noc = 3'd3; ndone = 0; lat = -1;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (done) begin ndone++; if (lat < 0) lat = c; end
            if (c == 7) check("restart_busy", 32'(busy), 32'd1);
            @(posedge clk); #1;
            start = (c + 1 == 2) || (c + 1 == 6);
        end
        check("repulse_done_count", 32'(ndone), 32'd1);
        check("repulse_done_cycle", 32'(lat), 32'd5);
        repeat (8) @(posedge clk); #1;

        // Reset mid-ISSUE at slot 1 of a 4-core read.
        set_req(16'h0020, 16'h0021, 16'h0022, 16'h0023, 8'h00, 8'h00, 8'h00, 8'h00);
        start = 1'b1; noc = 3'd4;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_read", 32'(rd), 32'd0);
        check("rst_ar1", 32'(ar[0]), 32'd0);
        check("rst_rdata1", 32'(rdata[0]), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        set_req(16'h0012, 16'h0000, 16'h0000, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00);
        run_batch(1'b0, 3'd1, -1, lat);
        check("post_rst_latency", 32'(lat), 32'd3);
        check("post_rst_rdata1", 32'(rdata[0]), 32'hA3);

`ifdef MEM_ACCESS_COUNT_EN
        run_batch(1'b0, 3'd2, -1, lat);
        run_batch(1'b1, 3'd1, -1, lat);
        check("count_three", 32'(acc_cnt), 32'd3);
        run_batch(1'b0, 3'd2, 4, lat);
        check("count_clr_wins", 32'(acc_cnt), 32'd0);
`endif

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            start = ($urandom_range(0, 3) == 0);
            we = 1'($urandom);
            noc = 3'($urandom_range(0, 7));
            for (int i = 0; i < 4; i++) begin
                addr[i] = 16'($urandom_range(0, 63));
                wdata[i] = 8'($urandom);
            end
`ifdef MEM_ACCESS_COUNT_EN
            count_clr = ($urandom_range(0, 31) == 0);
`endif
            @(posedge clk); #1;
        end
        start = 1'b0;
`ifdef MEM_ACCESS_COUNT_EN
        count_clr = 1'b0;
`endif
        repeat (10) @(posedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
